// File: rtl/serial_arbiter_pkg.sv
// Shared types and helpers for the serial_arbiter block.
// State encoding for the issue FSM and the gap-counter width helper.
package serial_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // The gap counter must be able to hold the value FROM itself.
  function automatic int gap_cnt_width(input int log2from);
    return log2from + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Request picker for serial_arbiter.
// Default: round-robin search starting at rr_ptr with wrap-around.
// With SERIAL_ARBITER_FIXED_PRIO_EN defined: lowest valid index wins and
// rr_ptr is ignored.
module rr_picker
  import serial_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2
) (
  input  logic [NREQ-1:0]     req,
  input  logic [LOG2NREQ-1:0] rr_ptr,
  output logic [NREQ-1:0]     gnt,
  output logic [LOG2NREQ-1:0] idx,
  output logic                any
);

`ifdef SERIAL_ARBITER_FIXED_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^rr_ptr;

  // Fixed priority: scan from the top down so the lowest valid index is written last
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = req[i] ? LOG2NREQ'(i) : idx;
      any = any | req[i];
    end
  end
`else
  logic [LOG2NREQ-1:0] cand_s;

  // Round-robin: scan offsets farthest-first so the nearest valid index at or above rr_ptr is written last
  always_comb begin
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand_s = LOG2NREQ'((int'(rr_ptr) + i) % NREQ);
      idx    = req[cand_s] ? cand_s : idx;
      any    = any | req[cand_s];
    end
  end
`endif

  // One-hot grant derived from the encoded winner
  always_comb begin
    gnt      = '0;
    gnt[idx] = any;
  end

endmodule

// File: rtl/serial_arbiter.sv
// serial_arbiter: shares one shift_serializer between NREQ requesters.
// A granted word is held and offered to the serializer; after the load the
// arbiter waits FROM+1 cycles (the serializer shift time) before issuing again.
// Optional macro SERIAL_ARBITER_FIXED_PRIO_EN selects fixed priority instead of
// round-robin (no rr_ptr register in that build).
module serial_arbiter
  import serial_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOG2NREQ = 2,
  parameter int FROM     = 16,
  parameter int LOG2FROM = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NREQ-1:0][FROM-1:0] req_data_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic [FROM-1:0]           ser_data_o,
  output logic                      ser_valid_o,
  input  logic                      ser_ready_i,
  output logic [LOG2NREQ-1:0]       grant_id_o,
  output logic                      busy_o
);

  localparam int                  CW       = gap_cnt_width(LOG2FROM);
  localparam logic [CW-1:0]       GAP_LOAD = CW'(FROM);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1'b1);
  localparam logic [LOG2NREQ-1:0] LAST_IDX = LOG2NREQ'(NREQ - 1);
  localparam logic [LOG2NREQ-1:0] IDX_ONE  = LOG2NREQ'(1'b1);

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [FROM-1:0]     hold_r;
  logic [CW-1:0]       cnt_r;
  logic [LOG2NREQ-1:0] grant_r;
  logic [LOG2NREQ-1:0] rr_ptr_s;
  logic                ser_valid_r;
  logic                busy_r;

  logic [NREQ-1:0]     pick_gnt_s;
  logic [LOG2NREQ-1:0] pick_idx_s;
  logic                pick_any_s;
  logic                arb_open_s;
  logic                accept_s;
  logic                cnt_zero_s;

  rr_picker #(
    .NREQ     (NREQ),
    .LOG2NREQ (LOG2NREQ)
  ) u_picker (
    .req    (req_valid_i),
    .rr_ptr (rr_ptr_s),
    .gnt    (pick_gnt_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  assign cnt_zero_s = (cnt_r == '0);
  // Arbitration is open when idle, or in the final gap cycle (counter at 0).
  assign arb_open_s = (state_r == IDLE) | ((state_r == GAP) & cnt_zero_s);
  // Gating with reset_n keeps the accept strobe low while reset is asserted.
  assign accept_s   = arb_open_s & pick_any_s & reset_n;

  assign req_ready_o = {NREQ{accept_s}} & pick_gnt_s;
  assign ser_data_o  = hold_r;
  assign ser_valid_o = ser_valid_r;
  assign grant_id_o  = grant_r;
  assign busy_o      = busy_r;

`ifdef SERIAL_ARBITER_FIXED_PRIO_EN
  assign rr_ptr_s = '0;
`else
  logic [LOG2NREQ-1:0] rr_ptr_r;

  // Round-robin pointer: next search starts just past the latest winner
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= (pick_idx_s == LAST_IDX) ? '0 : (pick_idx_s + IDX_ONE);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign rr_ptr_s = rr_ptr_r;
`endif

  // Next-state decode for IDLE / ISSUE / GAP
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (ser_ready_i) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      GAP: begin
        if (!cnt_zero_s) begin
          state_nxt_s = GAP;
        end else if (accept_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered valid/busy outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ser_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ser_valid_r <= (state_nxt_s == ISSUE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  // Hold register and grant index: captured only on an accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_r  <= '0;
      grant_r <= '0;
    end else if (accept_s) begin
      hold_r  <= req_data_i[pick_idx_s];
      grant_r <= pick_idx_s;
    end else begin
      hold_r  <= hold_r;
      grant_r <= grant_r;
    end
  end

  // Gap counter: loaded with FROM on serializer load, counts down to 0 and stays there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if ((state_r == ISSUE) && ser_ready_i) begin
      cnt_r <= GAP_LOAD;
    end else if ((state_r == GAP) && !cnt_zero_s) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule
